// File: rtl/secded_pkg.sv
// Extended-Hamming SECDED helpers. Functions take the check-bit count m and work
// on vectors sized for the largest supported code; callers zero-extend or truncate.
package secded_pkg;
  localparam int unsigned MAX_M = 11;
  localparam int unsigned MAX_N = 32'd1 << (MAX_M - 1);
  localparam int unsigned MAX_K = MAX_N - MAX_M;

  function automatic int unsigned data_width(input int unsigned m);
    return (32'd1 << (m - 1)) - m;
  endfunction

  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Positions 1..n-1 whose index has bit i set: the coverage set of check bit i.
  function automatic logic [MAX_N-1:0] cover_mask(input int unsigned i, input int unsigned n);
    logic [MAX_N-1:0] mask;
    mask = '0;
    for (int unsigned pos = 1; pos < MAX_N; pos++) begin
      mask[pos] = (pos < n) && pos[i];
    end
    return mask;
  endfunction

  function automatic logic [MAX_N-1:0] encode(input int unsigned m, input logic [MAX_K-1:0] data);
    logic [MAX_N-1:0] cw;
    int unsigned      d;
    int unsigned      n;
    cw = '0;
    d  = 0;
    n  = 32'd1 << (m - 1);
    for (int unsigned pos = 1; pos < MAX_N; pos++) begin
      if (pos < n && !is_pow2(pos)) begin
        cw[pos] = data[d];
        d++;
      end
    end
    // Check-bit positions are never covered by another check bit, so order is irrelevant.
    for (int unsigned i = 0; i < MAX_M - 1; i++) begin
      if (i < m - 1) cw[1 << i] = ^(cw & cover_mask(i, n));
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  // Recomputed check XOR stored check, folded into one parity over each coverage set.
  function automatic logic [MAX_M-2:0] syndrome(input int unsigned m, input logic [MAX_N-1:0] cw);
    logic [MAX_M-2:0] s;
    int unsigned      n;
    s = '0;
    n = 32'd1 << (m - 1);
    for (int unsigned i = 0; i < MAX_M - 1; i++) begin
      if (i < m - 1) s[i] = ^(cw & cover_mask(i, n));
    end
    return s;
  endfunction

  function automatic logic [MAX_K-1:0] extract(input int unsigned m, input logic [MAX_N-1:0] cw);
    logic [MAX_K-1:0] data;
    int unsigned      d;
    int unsigned      n;
    data = '0;
    d    = 0;
    n    = 32'd1 << (m - 1);
    for (int unsigned pos = 1; pos < MAX_N; pos++) begin
      if (pos < n && !is_pow2(pos)) begin
        data[d] = cw[pos];
        d++;
      end
    end
    return data;
  endfunction
endpackage

// File: rtl/secded_mem_reg_decoder.sv
// Combinational SECDED decode: corrects any single-bit error, flags single and double errors.
module secded_decoder
  import secded_pkg::*;
#(
  parameter  int unsigned M = 10,
  localparam int unsigned K = data_width(M),
  localparam int unsigned N = K + M,
  localparam int unsigned S = M - 1
) (
  input  logic [N-1:0] codeword,
  output logic [K-1:0] data,
  output logic         error
);
  logic [S-1:0] syn;
  logic         parity;
  logic [N-1:0] corrected;

  assign syn    = S'(syndrome(M, MAX_N'(codeword)));
  assign parity = ^codeword;

  // Odd parity means exactly one flip; syndrome 0 then points at the parity bit itself.
  always_comb begin
    corrected = codeword;
    if (parity) corrected[syn] = ~codeword[syn];
  end

  assign data  = K'(extract(M, MAX_N'(corrected)));
  assign error = parity | (syn != '0);
endmodule

// File: rtl/secded_mem_reg.sv
// Single-entry SECDED-protected register: encode on write, continuous decode on read.
module secded_mem_reg
  import secded_pkg::*;
#(
  parameter  int unsigned M = 10,
  localparam int unsigned K = data_width(M),
  localparam int unsigned N = K + M
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we,
  input  logic [K-1:0] data_in,
  output logic [K-1:0] data_out,
  output logic         error
);
  logic [N-1:0] codeword_q;
  logic [N-1:0] codeword_next;

  always_comb begin
    codeword_next = codeword_q;
    if (we) codeword_next = N'(encode(M, MAX_K'(data_in)));
  end

  // All-zeros is a valid codeword, so reset yields clean zero data.
  always_ff @(posedge clock) begin
    if (reset) codeword_q <= '0;
    else       codeword_q <= codeword_next;
  end

  secded_decoder #(.M(M)) u_decoder (
    .codeword (codeword_q),
    .data     (data_out),
    .error    (error)
  );
endmodule

// File: tb/tb_secded_mem_reg.sv
// Scoreboard bench for secded_mem_reg at M=3, 4 and 10 with fault injection on the stored codeword.
module tb_secded_mem_reg;
  logic         clock = 1'b0;
  logic         reset;
  logic         we3, we4, we10;
  logic [0:0]   din3, dout3;
  logic [3:0]   din4, dout4;
  logic [501:0] din10, dout10;
  logic         err3, err4, err10;
  logic [7:0]   inj4;
  logic [511:0] inj10;
  logic [511:0] rnd;
  logic [501:0] model10;

  always #5 clock = ~clock;

  secded_mem_reg #(.M(3)) dut3 (
    .clock(clock), .reset(reset), .we(we3), .data_in(din3), .data_out(dout3), .error(err3)
  );
  secded_mem_reg #(.M(4)) dut4 (
    .clock(clock), .reset(reset), .we(we4), .data_in(din4), .data_out(dout4), .error(err4)
  );
  secded_mem_reg #(.M(10)) dut10 (
    .clock(clock), .reset(reset), .we(we10), .data_in(din10), .data_out(dout10), .error(err10)
  );

  typedef struct {
    int unsigned  due;
    int           w;
    logic [501:0] data;
    logic         err;
    string        name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [501:0] act, logic [501:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  task automatic expect_at(int unsigned due, int w, logic [501:0] d, logic e, string name);
    exp_t x;
    x.due  = due;
    x.w    = w;
    x.data = d;
    x.err  = e;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs are sampled on the falling edge, one cycle's expectations at a time.
  always @(negedge clock) begin
    exp_t         x;
    logic [501:0] act;
    logic         act_err;
    while (q.size() > 0 && q[0].due <= cyc) begin
      x = q.pop_front();
      case (x.w)
        3:       begin act = 502'(dout3); act_err = err3; end
        4:       begin act = 502'(dout4); act_err = err4; end
        default: begin act = dout10;      act_err = err10; end
      endcase
      check({x.name, "_data"}, act, x.data);
      check({x.name, "_err"}, 502'(act_err), 502'(x.err));
    end
  end

  initial begin
    reset = 1'b1;
    we3 = 1'b0; we4 = 1'b0; we10 = 1'b0;
    din3 = '0; din4 = '0; din10 = '0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    expect_at(cyc, 3, '0, 1'b0, "rst3");
    expect_at(cyc, 4, '0, 1'b0, "rst4");
    expect_at(cyc, 10, '0, 1'b0, "rst10");

    // M=4 write, hold, and the hand-encoded codeword for 4'hA
    tick; we4 = 1'b1; din4 = 4'hA; expect_at(cyc + 1, 4, 502'hA, 1'b0, "wr4");
    tick; we4 = 1'b0; din4 = 4'h5; expect_at(cyc + 1, 4, 502'hA, 1'b0, "hold4");
    tick;
    check("cw4", 502'(dut4.codeword_q), 502'hA5);
    expect_at(cyc, 4, 502'hA, 1'b0, "hold4b");

    // Single-bit faults at every codeword position
    for (int i = 0; i < 8; i++) begin
      tick;
      inj4 = 8'hA5 ^ (8'd1 << i);
      force dut4.codeword_q = inj4;
      expect_at(cyc, 4, 502'hA, 1'b1, $sformatf("sec4_b%0d", i));
      @(negedge clock);
      #1 release dut4.codeword_q;
    end
    tick; we4 = 1'b1; din4 = 4'hA; expect_at(cyc + 1, 4, 502'hA, 1'b0, "rewr4");
    tick; we4 = 1'b0;

    // Reset wins over a simultaneous write
    reset = 1'b1; we4 = 1'b1; din4 = 4'hF; expect_at(cyc + 1, 4, '0, 1'b0, "rstpri4");
    tick; reset = 1'b0; we4 = 1'b0;

    // M=3 boundary: single data bit
    we3 = 1'b1; din3 = 1'b1; expect_at(cyc + 1, 3, 502'h1, 1'b0, "wr3_1");
    tick; din3 = 1'b0; expect_at(cyc + 1, 3, '0, 1'b0, "wr3_0");
    tick; we3 = 1'b0; din3 = 1'b1; expect_at(cyc + 1, 3, '0, 1'b0, "hold3");
    tick;

    // M=10 random writes against a last-written model
    model10 = '0;
    for (int t = 0; t < 10000; t++) begin
      we10 = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) rnd[j*32 +: 32] = $urandom;
      din10 = rnd[501:0];
      if (we10) model10 = din10;
      expect_at(cyc + 1, 10, model10, 1'b0, "rnd10");
      tick;
    end

    // M=10 double error on data positions 3 and 5 of an all-zero codeword
    we10 = 1'b1; din10 = '0; expect_at(cyc + 1, 10, '0, 1'b0, "wr0_10");
    tick; we10 = 1'b0;
    tick;
    inj10 = '0;
    inj10[3] = 1'b1;
    inj10[5] = 1'b1;
    force dut10.codeword_q = inj10;
    expect_at(cyc, 10, 502'h3, 1'b1, "ded10");
    @(negedge clock);
    #1 release dut10.codeword_q;
    reset = 1'b1;
    expect_at(cyc + 1, 10, '0, 1'b0, "rst10b");
    tick; reset = 1'b0;

    for (int k = 0; k < 5 && q.size() > 0; k++) tick;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
